// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Producer/consumer handshake bundle for nibble_serial_adder_ctrl.
// Optional macro NIBBLE_SERIAL_SUB_EN adds the op_sub request bit.
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef NIBBLE_SERIAL_SUB_EN
    logic             op_sub;

    modport master (
        output in_valid, a, b, cin, op_sub, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
    modport slave (
        input  in_valid, a, b, cin, op_sub, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`endif
endinterface

// File: rtl/nibble_serial_adder_ctrl_add4_slice.sv
// Combinational 4-bit ripple-carry adder slice, shared across all nibble passes.
module add4_slice
    import nibble_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);
    logic [NIBBLE_W:0] c;

    // Bitwise ripple: each stage consumes the carry of the one below.
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < NIBBLE_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder sequencer: one shared 4-bit slice, LSB nibble first,
// carry kept in a register between passes.
// Optional macro NIBBLE_SERIAL_SUB_EN adds subtraction (a - b) via op_sub.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand set
// RUN   | one nibble per cycle through the slice
// DONE  | result presented, waiting for out_ready
module nibble_serial_adder_ctrl
    import nibble_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic                        clk,
    input logic                        rst_n,
    nibble_serial_adder_ctrl_if.slave  bus
);
    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t               state_q;
    state_t               state_d;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     sum_q;
    logic                 carry_q;
    logic                 cout_q;
    logic [IDX_W-1:0]     idx_q;
    logic [NIBBLE_W-1:0]  a_nib;
    logic [NIBBLE_W-1:0]  b_nib;
    logic [NIBBLE_W-1:0]  slice_sum;
    logic                 slice_cout;
    logic                 accept;
    logic                 last_nib;
`ifdef NIBBLE_SERIAL_SUB_EN
    logic                 sub_q;
`endif

    assign accept   = (state_q == IDLE) && bus.in_valid;
    assign last_nib = (idx_q == LAST_IDX);
    assign a_nib    = a_q[idx_q * NIBBLE_W +: NIBBLE_W];
`ifdef NIBBLE_SERIAL_SUB_EN
    // Subtraction is a + ~b + 1; the +1 comes from the preset carry.
    assign b_nib    = sub_q ? ~b_q[idx_q * NIBBLE_W +: NIBBLE_W]
                            :  b_q[idx_q * NIBBLE_W +: NIBBLE_W];
`else
    assign b_nib    = b_q[idx_q * NIBBLE_W +: NIBBLE_W];
`endif

    add4_slice u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = RUN;
            RUN:     if (last_nib)      state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.busy      = (state_q == RUN) || (state_q == DONE);
        bus.sum       = sum_q;
        bus.cout      = cout_q;
    end

    // Operand capture on accept, then one nibble written per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
`ifdef NIBBLE_SERIAL_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            idx_q   <= '0;
`ifdef NIBBLE_SERIAL_SUB_EN
            sub_q   <= bus.op_sub;
            carry_q <= bus.op_sub ? 1'b1 : bus.cin;
`else
            carry_q <= bus.cin;
`endif
        end else if (state_q == RUN) begin
            sum_q[idx_q * NIBBLE_W +: NIBBLE_W] <= slice_sum;
            carry_q <= slice_cout;
            if (last_nib) cout_q <= slice_cout;
            else          idx_q  <= idx_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (WIDTH=16).
// Expected results come from plain integer arithmetic on the operands.
module tb_nibble_serial_adder_ctrl;
    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_sub(input logic sv);
`ifdef NIBBLE_SERIAL_SUB_EN
        bus.op_sub = sv;
`else
        if (sv) $display("note: subtract request ignored in add-only build");
`endif
    endtask

    // Reference: a+b+cin, or a-b with cout = no-borrow.
    task automatic model(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                         input logic sv, output logic [15:0] esum, output logic ecout);
        logic [16:0] full;
        if (sv) begin
            esum  = av - bv;
            ecout = (av >= bv);
        end else begin
            full  = {1'b0, av} + {1'b0, bv} + 17'(cv);
            esum  = full[15:0];
            ecout = full[16];
        end
    endtask

    // One full transaction, entered and left on a falling edge.
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                          input logic sv, input int stall);
        logic [15:0] esum;
        logic        ecout;
        int          n;
        model(av, bv, cv, sv, esum, ecout);
        bus.in_valid  = 1'b1;
        bus.a         = av;
        bus.b         = bv;
        bus.cin       = cv;
        set_sub(sv);
        bus.out_ready = (stall == 0);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) check_val("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        bus.cin      = 1'($urandom);
        set_sub(1'($urandom));
        n = 0;
        while (!bus.out_valid && n < 50) begin
            check_val("run_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check_val("run_busy", {31'd0, bus.busy}, 32'd1);
            @(negedge clk);
            n++;
        end
        check_val("latency", n, NIBBLES);
        check_val("sum", {16'd0, bus.sum}, {16'd0, esum});
        check_val("cout", {31'd0, bus.cout}, {31'd0, ecout});
        check_val("done_in_ready", {31'd0, bus.in_ready}, 32'd0);
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 16'($urandom);
            bus.b        = 16'($urandom);
            @(negedge clk);
            check_val("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            check_val("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check_val("stall_sum", {16'd0, bus.sum}, {16'd0, esum});
            check_val("stall_cout", {31'd0, bus.cout}, {31'd0, ecout});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_val("post_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_val("post_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check_val("post_busy", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
        set_sub(1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check_val("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_val("rst_sum", {16'd0, bus.sum}, 32'd0);
        check_val("rst_cout", {31'd0, bus.cout}, 32'd0);
        check_val("rst_busy", {31'd0, bus.busy}, 32'd0);

        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 0);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'hA5A5, 16'h5A5B, 1'b0, 1'b0, 5);
        run_op(16'h0F0F, 16'h0101, 1'b1, 1'b0, 0);

        // Abort mid-run: two nibbles processed, then asynchronous reset.
        bus.in_valid = 1'b1;
        bus.a        = 16'h1234;
        bus.b        = 16'h1111;
        bus.cin      = 1'b0;
        set_sub(1'b0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_val("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check_val("abort_sum", {16'd0, bus.sum}, 32'd0);
        check_val("abort_cout", {31'd0, bus.cout}, 32'd0);
        check_val("abort_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("abort_rel_in_ready", {31'd0, bus.in_ready}, 32'd1);
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 0);

`ifdef NIBBLE_SERIAL_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0);
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0);
`endif

        for (int k = 0; k < 40; k++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom),
`ifdef NIBBLE_SERIAL_SUB_EN
                   1'($urandom),
`else
                   1'b0,
`endif
                   int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that adds two WIDTH-bit operands with one shared 4-bit ripple-carry adder slice, one nibble per clock, LSB nibble first.
- Carry is held in a register between nibbles.
- Sits between a valid/ready producer and a valid/ready consumer. Trades latency (WIDTH/4 cycles) for area when a wide adder is not worth the gates.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4.
- NIBBLES, WIDTH/4, derived localparam; number of slice passes.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operand set available.
- in_ready  output  1  block can accept operands (IDLE only).
- a  input  WIDTH  operand A, sampled on accept.
- b  input  WIDTH  operand B, sampled on accept.
- cin  input  1  carry-in to LSB nibble, sampled on accept.
- out_valid  output  1  result available (DONE only).
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  result, registered.
- cout  output  1  carry out of MSB nibble, registered.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n=0, any time, asynchronous):
  - state=IDLE; operand regs, sum, cout, carry reg and nibble index all 0.
  - in_ready=1 and out_valid=0 after release.
- States:
  - IDLE: in_ready=1.
    - in_valid=1 latches a, b, cin into internal regs (carry reg <= cin), index <= 0, next RUN.
    - Otherwise stay in IDLE.
  - RUN: in_ready=0, out_valid=0.
    - Each cycle the slice adds a[4i+3:4i] + b[4i+3:4i] + carry reg, with i=index.
    - sum[4i+3:4i] <= slice sum; carry reg <= slice cout.
    - If index==NIBBLES-1: cout <= slice cout, next DONE. Else index <= index+1.
  - DONE: out_valid=1, in_ready=0; sum/cout held stable.
    - out_ready=1 completes the transfer; next IDLE.
    - out_ready=0 holds DONE indefinitely.
- Latency: accept edge k, out_valid high from edge k+NIBBLES. WIDTH=4 gives one RUN cycle.
- Throughput: max one operation per NIBBLES+2 cycles.
  - in_ready is only asserted in IDLE, so there is a mandatory bubble after a DONE handshake.
  - in_valid during RUN/DONE is ignored and does not corrupt the latched operands.
- Input changes after accept have no effect: operands are fully registered.
- sum nibbles not yet written during RUN hold stale values; sum is only meaningful while out_valid=1.
- Arithmetic is modulo 2^WIDTH; cout is the true carry out of bit WIDTH-1.
- Reset during RUN or DONE aborts the operation with no output handshake; the result is discarded.

Optional Feature:
- Macro: NIBBLE_SERIAL_SUB_EN.
- Defined: adds port op_sub (input, 1), sampled on accept with the operands.
  - op_sub=1: slice B input is ~b nibble, carry reg initialised to 1 (cin ignored).
  - Result is a-b mod 2^WIDTH; cout=1 means no borrow (a>=b unsigned).
  - op_sub=0: behaviour identical to the add-only build.
- Undefined: no op_sub port, add only.

Decomposition:
- Shared package nibble_adder_pkg:
  - state enum {IDLE, RUN, DONE}, 2 bits;
  - localparam NIBBLE_W=4.
- Sub-module add4_slice: the combinational 4-bit ripple-carry adder (sum[3:0], cout from a[3:0], b[3:0], cin), instantiated once.
- The controller holds the FSM, index counter, carry reg and the nibble mux/demux.

Test Plan (WIDTH=16):
- 0x1234 + 0x1111, cin=0, out_ready=1 -> out_valid exactly 4 cycles after accept; sum=0x2345, cout=0; in_ready back to 1 the cycle after the handshake.
- 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through every nibble pass). Also 0x0000 + 0x0000, cin=1 -> sum=0x0001, cout=0.
- Backpressure: out_ready=0 for 5 cycles in DONE, in_valid=1 with new operands -> sum/cout stable, in_ready=0, new operands not taken; then out_ready=1 -> IDLE, new operands accepted on the next IDLE cycle.
- Reset mid-RUN (rst_n low after nibble 2) -> immediately state IDLE, out_valid=0, sum=0, cout=0, in_ready=1 after release; next operation 0x0F0F + 0x00F1 -> 0x1000, cout=0.
- Operand change after accept: drive a=0x0001, b=0x0001 then change them during RUN -> sum=0x0002.
- With NIBBLE_SERIAL_SUB_EN:
  - 0x0005 - 0x0007 -> sum=0xFFFE, cout=0.
  - 0x0007 - 0x0005 -> sum=0x0002, cout=1.
  - op_sub=0 repeats the first add vector unchanged.
